// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch stage of the 8-bit CPU. Owns the program counter, issues
// reads to the synchronous instruction memory (data returns one cycle after
// the request) and buffers returned instructions in a small circular prefetch
// queue that feeds the decoder over a valid/ready handshake. A taken
// branch/jump from execute (redirect) flushes the queue, drops the data that
// returns in the redirect cycle and issues the target in that same cycle.
//
// Parameters
//   ADDR_W    PC / memory address width
//   INSTR_W   instruction width
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high; clears all state immediately
//   imem_req     out  read strobe to instruction memory
//   imem_addr    out  read address, valid with imem_req
//   imem_data    in   read data, valid one cycle after the request
//   redirect     in   taken branch/jump pulse from execute
//   redirect_pc  in   redirect target address
//   fetch_pc     out  next sequential fetch address (PC register)
//   ir_valid     out  queue head holds a valid instruction
//   ir_instr     out  head instruction (0 when empty)
//   ir_pc        out  head instruction address (0 when empty)
//   ir_ready     in   decoder accepts the head this cycle
//   stall_count  out  16-bit saturating decode-starvation counter
//                     (present only when FETCH_PERF_CNT_EN is defined)
//
// Build option
//   FETCH_PERF_CNT_EN  adds the stall_count port and counter.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 8,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_count
`endif
);

  localparam int unsigned     PTR_W   = $clog2(DEPTH);
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Queue storage: one entry = {pc, instr}. Not reset; validity comes from
  // the occupancy counter.
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  credit_used;

  // Credit: entries already held plus the one still on its way back. Only
  // registered occupancy is used, so a same-cycle pop never frees a slot.
  // CNT_W bits hold up to 2*DEPTH-1, enough for DEPTH+1.
  assign credit_used = count_q + CNT_W'(inflight_q);

  assign imem_addr = redirect ? redirect_pc : fetch_pc_q;
  assign imem_req  = ~reset & (redirect | (credit_used < DEPTH_C));

  // Data returning in a redirect cycle belongs to the old path: drop it.
  assign push = inflight_q & ~redirect;

  assign ir_valid = (count_q != '0);
  assign pop      = ir_valid & ir_ready;

  assign ir_instr = ir_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign ir_pc    = ir_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign fetch_pc = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (imem_req) begin
      fetch_pc_d = imem_addr + ADDR_W'(1);
      req_pc_d   = imem_addr;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (redirect) begin
      // Flush: any handshake this cycle is still consumed by the decoder,
      // the remainder is discarded by collapsing the read pointer.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= imem_req;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (ir_ready && !ir_valid && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

  // The credit rule guarantees a returning instruction always has a slot.
  no_write_when_full: assert property (
    @(posedge clk) disable iff (reset) !(push && (count_q == DEPTH_C))
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       ir_ready;

  // Default-RESET_PC instance
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_data = '0;
  logic [7:0] fetch_pc;
  logic       ir_valid;
  logic [7:0] ir_instr;
  logic [7:0] ir_pc;

  // RESET_PC = 8'hFE instance (wrap-around stream)
  logic       imem_req2;
  logic [7:0] imem_addr2;
  logic [7:0] imem_data2 = '0;
  logic       redirect2 = 1'b0;
  logic [7:0] redirect_pc2 = '0;
  logic [7:0] fetch_pc2;
  logic       ir_valid2;
  logic [7:0] ir_instr2;
  logic [7:0] ir_pc2;
  logic       ir_ready2;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] stall_count2;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  always #5 clk = ~clk;

  instr_fetch_queue #(.ADDR_W(8), .INSTR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .ir_valid(ir_valid), .ir_instr(ir_instr),
    .ir_pc(ir_pc), .ir_ready(ir_ready)
`ifdef FETCH_PERF_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  instr_fetch_queue #(.ADDR_W(8), .INSTR_W(8), .DEPTH(4), .RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .fetch_pc(fetch_pc2), .ir_valid(ir_valid2), .ir_instr(ir_instr2),
    .ir_pc(ir_pc2), .ir_ready(ir_ready2)
`ifdef FETCH_PERF_CNT_EN
    , .stall_count(stall_count2)
`endif
  );

  // Synchronous instruction memory: word[i] = i + 8'h10, one-cycle latency.
  always @(posedge clk) begin
    if (imem_req)  imem_data  <= imem_addr + 8'h10;
    if (imem_req2) imem_data2 <= imem_addr2 + 8'h10;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop one expected {pc,instr} per accepted beat.
  always @(negedge clk) begin
    if (ir_valid && ir_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected actual=%0h_%0h expected=none", ir_pc, ir_instr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({ir_pc, ir_instr} !== e) begin
          failures++;
          $display("FAIL beat actual=%0h_%0h expected=%0h_%0h", ir_pc, ir_instr, e[15:8], e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ir_valid2 && ir_ready2) begin
      checks++;
      if (exp2_q.size() == 0) begin
        failures++;
        $display("FAIL beat_fe_unexpected actual=%0h_%0h expected=none", ir_pc2, ir_instr2);
      end else begin
        logic [15:0] e;
        e = exp2_q.pop_front();
        if ({ir_pc2, ir_instr2} !== e) begin
          failures++;
          $display("FAIL beat_fe actual=%0h_%0h expected=%0h_%0h", ir_pc2, ir_instr2, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ir_ready    = 1'b1;
    ir_ready2   = 1'b1;

    // ---------------- reset values ----------------
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_ir_valid", 32'(ir_valid), 32'h0);
    check("rst_ir_instr", 32'(ir_instr), 32'h0);
    check("rst_ir_pc",    32'(ir_pc),    32'h0);
    check("rst_fetch_pc", 32'(fetch_pc), 32'h00);
    check("rst_fetch_pc_fe", 32'(fetch_pc2), 32'hFE);
`ifdef FETCH_PERF_CNT_EN
    check("rst_stall", 32'(stall_count), 32'h0);
`endif

    // Sequential stream up to the redirect: pc 00..09
    for (int unsigned i = 0; i < 10; i++) exp_q.push_back({8'(i), 8'(i + 8'h10)});
    exp2_q.push_back(16'hFE0E);
    exp2_q.push_back(16'hFF0F);
    exp2_q.push_back(16'h0010);
    exp2_q.push_back(16'h0111);
    exp2_q.push_back(16'h0212);
    exp2_q.push_back(16'h0313);

    @(posedge clk); #1;
    reset = 1'b0;
    // C1
    @(negedge clk);
    check("c1_imem_req",  32'(imem_req),  32'h1);
    check("c1_imem_addr", 32'(imem_addr), 32'h00);
    check("c1_ir_valid",  32'(ir_valid),  32'h0);
    check("c1_imem_addr_fe", 32'(imem_addr2), 32'hFE);
    step(); // C2
    @(negedge clk);
    check("c2_ir_valid",  32'(ir_valid),  32'h0);
    check("c2_imem_addr", 32'(imem_addr), 32'h01);
    step(); // C3
    @(negedge clk);
    check("c3_ir_valid", 32'(ir_valid), 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("c3_stall", 32'(stall_count), 32'h2);
`endif
    for (int unsigned c = 4; c <= 8; c++) begin
      step();
      @(negedge clk);
      check("stream_ir_valid", 32'(ir_valid), 32'h1);
    end

    // ---------------- decode stall: queue fills ----------------
    step(); // C9
    ir_ready  = 1'b0;
    ir_ready2 = 1'b0;
    repeat (9) step(); // C18
    @(negedge clk);
    check("full_imem_req", 32'(imem_req), 32'h0);
    check("full_ir_pc",    32'(ir_pc),    32'h06);
    check("full_fetch_pc", 32'(fetch_pc), 32'h0A);
    step(); // C19
    ir_ready = 1'b1;
    @(negedge clk);
    check("release_no_credit", 32'(imem_req), 32'h0);
    step(); // C20
    @(negedge clk);
    check("release_imem_req",  32'(imem_req),  32'h1);
    check("release_imem_addr", 32'(imem_addr), 32'h0A);
    step(); step(); // C22
    step(); // C23
    ir_ready = 1'b0;

    // ---------------- redirect with 3 queued entries ----------------
    step(); // C24
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    for (int unsigned i = 0; i < 4; i++) exp_q.push_back({8'(8'h40 + i), 8'(8'h50 + i)});
    @(negedge clk);
    check("redir_imem_req",  32'(imem_req),  32'h1);
    check("redir_imem_addr", 32'(imem_addr), 32'h40);
    check("redir_head_pc",   32'(ir_pc),     32'h0A);
    step(); // C25
    redirect = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    check("bubble_ir_valid",  32'(ir_valid),  32'h0);
    check("bubble_imem_addr", 32'(imem_addr), 32'h41);
`ifdef FETCH_PERF_CNT_EN
    check("bubble_stall", 32'(stall_count), 32'h2);
`endif
    step(); // C26
    @(negedge clk);
    check("target_ir_valid", 32'(ir_valid), 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("after_bubble_stall", 32'(stall_count), 32'h3);
`endif
    step(); step(); step(); // C29
    step(); // C30
    ir_ready = 1'b0;

    // ---------------- asynchronous reset mid-stream ----------------
    @(negedge clk);
    check("pre_reset_ir_valid", 32'(ir_valid), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("async_ir_valid", 32'(ir_valid), 32'h0);
    check("async_ir_pc",    32'(ir_pc),    32'h0);
    check("async_ir_instr", 32'(ir_instr), 32'h0);
    check("async_fetch_pc", 32'(fetch_pc), 32'h00);
    check("async_imem_req", 32'(imem_req), 32'h0);
    check("async_fetch_pc_fe", 32'(fetch_pc2), 32'hFE);
`ifdef FETCH_PERF_CNT_EN
    check("async_stall", 32'(stall_count), 32'h0);
`endif

    for (int unsigned i = 0; i < 4; i++) exp_q.push_back({8'(i), 8'(i + 8'h10)});
    @(posedge clk); @(posedge clk); #1;
    reset    = 1'b0;
    ir_ready = 1'b1;
    // C1'
    @(negedge clk);
    check("re_imem_req",  32'(imem_req),  32'h1);
    check("re_imem_addr", 32'(imem_addr), 32'h00);
    step(); // C2'
    @(negedge clk);
    check("re_c2_ir_valid", 32'(ir_valid), 32'h0);
    step(); // C3'
    @(negedge clk);
    check("re_c3_ir_valid", 32'(ir_valid), 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("re_c3_stall", 32'(stall_count), 32'h2);
`endif
    step(); step(); step(); // C6'
    step(); // C7'
    ir_ready = 1'b0;
    repeat (3) step();

    check("sb_drained",    32'(exp_q.size()),  32'h0);
    check("sb_fe_drained", 32'(exp2_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
